alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the datapath ALU, with valid/ready handshakes on input and output.
- Single-cycle logic/arith/shift ops plus iterative multiply (shift-add) and unsigned divide (restoring), both WIDTH cycles.
- Result and flags are registered and held until consumed.
- Sits between register-file read and writeback; the pipeline stalls on in_ready/out_valid.

---
 rtl/alu_mc.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_mc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith/shift ops,
// shift-add MUL and restoring DIVU (DIVU present only when ALU_MC_DIV_EN is defined).
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             zero,
    output logic             co,
    output logic             overflow,
    output logic             err,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpNor  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSltu = 4'b1000;
    localparam logic [3:0] OpSll  = 4'b1001;
    localparam logic [3:0] OpSra  = 4'b1010;
    localparam logic [3:0] OpMul  = 4'b1100;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OpDivu = 4'b1101;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] md_q, md_d;     // multiplicand or divisor
    logic [WIDTH-1:0] hi_q, hi_d;     // partial product high / remainder
    logic [WIDTH-1:0] lo_q, lo_d;     // multiplier / dividend-quotient
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             zero_q, zero_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             accept;
    logic             is_multi;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH-1:0] sub_w;
    logic [WIDTH-1:0] sc_res;
    logic             sc_co, sc_ovf, sc_err;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             step_err;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StBusy);
    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign zero      = zero_q;
    assign co        = co_q;
    assign overflow  = ovf_q;
    assign err       = err_q;

    assign shamt = b[SHW-1:0];
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = a - b;

    // One shift-add step: conditionally add, then shift {carry, hi, lo} right.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
    logic             is_div_q, is_div_d;
    logic [WIDTH:0]   rem_sh, rem_n;
    logic             div_ge;

    // With a zero divisor every step subtracts 0 and sets the quotient bit, so the
    // quotient naturally ends all ones and the remainder ends equal to the dividend.
    assign rem_sh  = {hi_q, lo_q[WIDTH-1]};
    assign div_ge  = (rem_sh >= {1'b0, md_q});
    assign rem_n   = div_ge ? (rem_sh - {1'b0, md_q}) : rem_sh;
    assign step_hi = is_div_q ? rem_n[WIDTH-1:0] : mul_hi;
    assign step_lo = is_div_q ? {lo_q[WIDTH-2:0], div_ge} : mul_lo;
    assign step_err = is_div_q && (md_q == '0);
    assign is_multi = (op == OpMul) || (op == OpDivu);
`else
    assign step_hi  = mul_hi;
    assign step_lo  = mul_lo;
    assign step_err = 1'b0;
    assign is_multi = (op == OpMul);
`endif

    always_comb begin
        sc_res = '0;
        sc_co  = 1'b0;
        sc_ovf = 1'b0;
        sc_err = 1'b0;
        case (op)
            OpAnd:  sc_res = a & b;
            OpOr:   sc_res = a | b;
            OpAdd: begin
                sc_res = add_w[WIDTH-1:0];
                sc_co  = add_w[WIDTH];
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OpXor:  sc_res = a ^ b;
            OpNor:  sc_res = ~(a | b);
            OpSrl:  sc_res = a >> shamt;
            OpSub: begin
                sc_res = sub_w;
                sc_co  = (a < b);
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OpSlt:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OpSltu: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OpSll:  sc_res = a << shamt;
            OpSra:  sc_res = $unsigned($signed(a) >>> shamt);
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_d     = md_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        zero_d   = zero_q;
        co_d     = co_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
`ifdef ALU_MC_DIV_EN
        is_div_d = is_div_q;
`endif
        case (state_q)
            StBusy: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = StDone;
                    cnt_d    = '0;
                    res_d    = step_lo;
                    res_hi_d = step_hi;
                    zero_d   = (step_lo == '0);
                    co_d     = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = step_err;
                end
            end
            default: begin
                if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    if (is_multi) begin
                        state_d = StBusy;
                        cnt_d   = SHW'(WIDTH - 1);
                        hi_d    = '0;
`ifdef ALU_MC_DIV_EN
                        is_div_d = (op == OpDivu);
                        md_d     = (op == OpDivu) ? b : a;
                        lo_d     = (op == OpDivu) ? a : b;
`else
                        md_d     = a;
                        lo_d     = b;
`endif
                    end else begin
                        state_d  = StDone;
                        res_d    = sc_res;
                        res_hi_d = '0;
                        zero_d   = (sc_res == '0);
                        co_d     = sc_co;
                        ovf_d    = sc_ovf;
                        err_d    = sc_err;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            md_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_MC_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            md_q     <= md_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
`ifdef ALU_MC_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32); DIVU expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'b0000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] res, res_hi;
    logic        zero, co, overflow, err, busy;

    int checks = 0;
    int errors = 0;
    int lat;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_hi    (res_hi),
        .zero      (zero),
        .co        (co),
        .overflow  (overflow),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one op for one cycle, scramble inputs afterwards, count cycles to out_valid.
    task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int l);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        chk("in_ready_at_issue", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        l = 1;
        while (!out_valid && l < 100) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_consume", out_valid, 0);
    endtask

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res", res, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // ADD signed overflow
        run(4'b0010, 32'h7FFF_FFFF, 32'h1, lat);
        chk("add_lat", lat, 1);
        chk("add_res", res, 64'h8000_0000);
        chk("add_ovf", overflow, 1);
        chk("add_co", co, 0);
        chk("add_zero", zero, 0);
        chk("add_err", err, 0);
        consume();

        // SUB borrow
        run(4'b0110, 32'd3, 32'd5, lat);
        chk("sub_res", res, 64'hFFFF_FFFE);
        chk("sub_co", co, 1);
        chk("sub_ovf", overflow, 0);
        consume();

        // Back-to-back SUB then SLT with out_ready held high
        @(negedge clk);
        out_ready = 1'b1;
        op = 4'b0110; a = 32'd5; b = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_sub_valid", out_valid, 1);
        chk("b2b_sub_res", res, 0);
        chk("b2b_sub_zero", zero, 1);
        chk("b2b_sub_co", co, 0);
        chk("b2b_in_ready", in_ready, 1);
        op = 4'b0111; a = 32'hFFFF_FFFF; b = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_slt_valid", out_valid, 1);
        chk("b2b_slt_res", res, 1);
        chk("b2b_slt_zero", zero, 0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_idle", out_valid, 0);

        // SLL ignores upper bits of b
        run(4'b1001, 32'h1, 32'h21, lat);
        chk("sll_res", res, 2);
        consume();

        // MUL
        run(4'b1100, 32'h0001_0000, 32'h0001_0000, lat);
        chk("mul_lat", lat, 33);
        chk("mul_res", res, 0);
        chk("mul_res_hi", res_hi, 1);
        chk("mul_zero", zero, 1);
        chk("mul_busy_done", busy, 0);
        consume();
        run(4'b1100, 32'hFFFF_FFFF, 32'h3, lat);
        chk("mul2_res", res, 64'hFFFF_FFFD);
        chk("mul2_res_hi", res_hi, 2);
        consume();

        // DIVU
`ifdef ALU_MC_DIV_EN
        run(4'b1101, 32'd100, 32'd7, lat);
        chk("div_lat", lat, 33);
        chk("div_res", res, 14);
        chk("div_res_hi", res_hi, 2);
        chk("div_err", err, 0);
        consume();
        run(4'b1101, 32'd100, 32'd0, lat);
        chk("div0_lat", lat, 33);
        chk("div0_res", res, 64'hFFFF_FFFF);
        chk("div0_res_hi", res_hi, 100);
        chk("div0_err", err, 1);
        consume();
`else
        run(4'b1101, 32'd100, 32'd7, lat);
        chk("nodiv_lat", lat, 1);
        chk("nodiv_res", res, 0);
        chk("nodiv_res_hi", res_hi, 0);
        chk("nodiv_err", err, 1);
        consume();
`endif

        // Illegal op
        run(4'b1111, 32'h55, 32'h66, lat);
        chk("ill_lat", lat, 1);
        chk("ill_err", err, 1);
        chk("ill_res", res, 0);
        chk("ill_res_hi", res_hi, 0);
        consume();

        // SRA held under back-pressure
        run(4'b1010, 32'h8000_0000, 32'd4, lat);
        chk("sra_lat", lat, 1);
        for (int i = 0; i < 10; i++) begin
            chk("sra_hold_res", res, 64'hF800_0000);
            chk("sra_hold_in_ready", in_ready, 0);
            chk("sra_hold_valid", out_valid, 1);
            @(negedge clk);
        end
        consume();

        // Reset during MUL
        @(negedge clk);
        op = 4'b1100; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mul_busy", busy, 1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_res", res, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'b0010, 32'd2, 32'd3, lat);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_res", res, 5);
        chk("post_rst_res_hi", res_hi, 0);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
